sdx_pad_ctrl: RTL
=================

# sdx_pad_ctrl

Multi-channel SDX pad controller that replaces the fixed single-pad, I2C-only pad mapping. Each channel has a run-time mode: input-only, open-drain (I2C style) or push-pull. The block adds an input synchroniser, an optional glitch filter and a bus-turnaround sequence on every mode change. It sits between the pad ring and core protocol blocks such as the I2C delay block and the OTP serial engine.

## Interface
- NUM_CH, 4: number of independent pad channels (1..16).
- FILT_LEN, 3: glitch-filter length in clk cycles (1..255).
- TURN_CYC, 4: turnaround cycles with output released on a mode change (1..255).
- clk  input  1  block clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode_i  input  2*NUM_CH  requested mode per channel; channel n uses bits [2n+1:2n].
- mode_we  input  NUM_CH  per-channel mode write strobe, one cycle.
- core_do  input  NUM_CH  data from core, e.g. the I2C SDA output.
- core_di  output  NUM_CH  synchronised, filtered pad input to core.
- busy  output  NUM_CH  channel is in turnaround.
- pad_in  input  NUM_CH  raw pad input, asynchronous.
- pad_out  output  NUM_CH  pad output value.
- pad_oe_n  output  NUM_CH  pad output enable, active low.

## Operation
- Mode encoding:
  - 2'b00 HIZ: pad_out=0, pad_oe_n=1.
  - 2'b01 OD: pad_out=0, pad_oe_n=core_do, so the pad drives low only while core_do=0.
  - 2'b10 PP: pad_out=core_do, pad_oe_n=0.
  - 2'b11 is reserved and behaves as HIZ.
- Per-channel FSM states are ACTIVE and TURN.
  - ACTIVE: pads follow cur_mode. When mode_we[n]=1 and mode_i[n]≠cur_mode, latch pend_mode, load turn_cnt=TURN_CYC-1 and go to TURN. When mode_we[n]=1 and mode_i[n]=cur_mode, do nothing.
  - TURN: pad_out=0, pad_oe_n=1, busy=1. turn_cnt decrements each cycle. At turn_cnt=0, set cur_mode=pend_mode and return to ACTIVE.
  - A mode_we during TURN updates pend_mode and reloads turn_cnt=TURN_CYC-1, restarting the full turnaround. This applies even if the new value equals cur_mode.
- Input path: pad_in passes through a 2-flop synchroniser, then the filter, to produce core_di. The input path is independent of mode and runs in HIZ and TURN as well.
- Filter: a per-channel counter of width $clog2(FILT_LEN+1).
  - The counter clears whenever the synchronised value equals core_di.
  - Otherwise it increments.
  - core_di takes the new value, and the counter clears, on the edge where the counter would reach FILT_LEN.
  - Pulses shorter than FILT_LEN cycles after the synchroniser are rejected.
- Channels are fully independent; simultaneous writes to several channels are all honoured.

## Timing
- Reset values: pad_oe_n all 1, pad_out all 0, core_di all 1 (idle-high bus), busy 0, cur_mode/pend_mode HIZ, all counters 0.
- pad_out and pad_oe_n are registered: a core_do change appears at the pad 1 cycle later.
- TURN entry: the edge sampling mode_we releases the output in the same cycle the registered outputs update. busy is high for exactly TURN_CYC cycles. The new mode drives the pad on the following cycle.
- Input latency: a pad_in change sampled at edge k reaches core_di at edge k+1+FILT_LEN, i.e. 2+FILT_LEN cycles end-to-end. The filter-disabled latency is 2 cycles.
- Reset asserted mid-turnaround or mid-filter returns every output to its reset value immediately and asynchronously. Release is synchronous to clk through the standard reset synchroniser upstream.

## Configuration
- SDX_GLITCH_FILT_EN defined: the filter is present as described and FILT_LEN is honoured.
- SDX_GLITCH_FILT_EN undefined: the filter is removed, core_di equals the synchroniser output (latency 2), FILT_LEN is ignored, and no counter flops exist.

## Structure
- Package sdx_pad_pkg holds:
  - the mode enum/localparams SDX_MODE_HIZ/OD/PP/RSV;
  - the FSM state encoding;
  - the default FILT_LEN and TURN_CYC constants.
- Sub-module sdx_pad_chan implements one channel (FSM, synchroniser, filter, output registers). The top sdx_pad_ctrl instantiates it NUM_CH times via generate and slices the buses.

## Test plan
- Reset: assert rst with random inputs → pad_oe_n=all 1, pad_out=0, core_di=all 1, busy=0. After release, pad_in=0 on ch0 → core_di[0]=0 after 5 cycles (FILT_LEN=3).
- OD mode: write 2'b01 to ch1 → busy[1] high 4 cycles. Then core_do[1]=0 → pad_oe_n[1]=0 and pad_out[1]=0 one cycle later. core_do[1]=1 → pad_oe_n[1]=1.
- Glitch: pad_in[2] low for 2 cycles → core_di[2] stays 1. Low for 3 cycles → core_di[2]=0 at 5 cycles after the first low sample.
- Re-write in TURN: PP write to ch3, then an OD write after 2 busy cycles → busy[3] high for 6 cycles total, then OD applies. No PP drive is ever seen.
- Simultaneous: mode_we=4'b1111 with mode 2'b10 on all channels → all busy for 4 cycles, then pad_out follows core_do with pad_oe_n=0. Reset asserted during turnaround → immediate return to reset values.
- Filter disabled (SDX_GLITCH_FILT_EN undefined): a 1-cycle pad_in pulse appears on core_di 2 cycles later for exactly 1 cycle.

Source files
------------

// File: rtl/sdx_pad_pkg.sv
`default_nettype none
// ============================================================================
// sdx_pad_pkg : shared types and defaults for the SDX pad controller
// Rev 1.0
// ============================================================================
package sdx_pad_pkg;

  typedef enum logic [1:0] {
    SDX_MODE_HIZ = 2'b00,
    SDX_MODE_OD  = 2'b01,
    SDX_MODE_PP  = 2'b10,
    SDX_MODE_RSV = 2'b11
  } sdx_mode_e;

  typedef enum logic {
    SDX_ST_ACTIVE = 1'b0,
    SDX_ST_TURN   = 1'b1
  } sdx_state_e;

  localparam int SDX_FILT_LEN_DEF = 3;
  localparam int SDX_TURN_CYC_DEF = 4;

  typedef struct packed {
    logic out;
    logic oe_n;
  } sdx_drive_t;

  // Reserved mode falls into the default arm and therefore releases the pad.
  function automatic sdx_drive_t sdx_mode_drive(input sdx_mode_e mode, input logic data);
    sdx_drive_t d;
    d.out  = 1'b0;
    d.oe_n = 1'b1;
    case (mode)
      SDX_MODE_OD: d.oe_n = data;
      SDX_MODE_PP: begin
        d.out  = data;
        d.oe_n = 1'b0;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdx_pad_chan.sv
`default_nettype none
// ============================================================================
// sdx_pad_chan : one pad channel - mode FSM with turnaround, output registers,
// input synchroniser and optional glitch filter (SDX_GLITCH_FILT_EN).
// Rev 1.0
// ============================================================================
module sdx_pad_chan
  import sdx_pad_pkg::*;
#(
  parameter int TURN_CYC = SDX_TURN_CYC_DEF
`ifdef SDX_GLITCH_FILT_EN
  ,
  parameter int FILT_LEN = SDX_FILT_LEN_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_in,
  input  logic       mode_we,
  input  logic       core_do,
  input  logic       pad_in,
  output logic       core_di,
  output logic       busy,
  output logic       pad_out,
  output logic       pad_oe_n
);

  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYC - 1);

  sdx_state_e state, state_nxt;
  sdx_mode_e  cur_mode, cur_nxt, pend_mode, pend_nxt, mode_req;
  logic [7:0] turn_cnt, cnt_nxt;
  sdx_drive_t drive_nxt;

  assign mode_req = sdx_mode_e'(mode_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SDX_ST_ACTIVE;
      cur_mode  <= SDX_MODE_HIZ;
      pend_mode <= SDX_MODE_HIZ;
      turn_cnt  <= '0;
      pad_out   <= 1'b0;
      pad_oe_n  <= 1'b1;
    end else begin
      state     <= state_nxt;
      cur_mode  <= cur_nxt;
      pend_mode <= pend_nxt;
      turn_cnt  <= cnt_nxt;
      pad_out   <= drive_nxt.out;
      pad_oe_n  <= drive_nxt.oe_n;
    end
  end

  // Pad registers follow the next state so the release lands on the write edge.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_mode;
    pend_nxt  = pend_mode;
    cnt_nxt   = turn_cnt;
    case (state)
      SDX_ST_ACTIVE: begin
        if (mode_we && (mode_req != cur_mode)) begin
          pend_nxt  = mode_req;
          cnt_nxt   = TURN_LOAD;
          state_nxt = SDX_ST_TURN;
        end
      end
      SDX_ST_TURN: begin
        if (mode_we) begin
          pend_nxt = mode_req;
          cnt_nxt  = TURN_LOAD;
        end else if (turn_cnt == 8'd0) begin
          cur_nxt   = pend_mode;
          state_nxt = SDX_ST_ACTIVE;
        end else begin
          cnt_nxt = turn_cnt - 8'd1;
        end
      end
      default: state_nxt = SDX_ST_ACTIVE;
    endcase
    if (state_nxt == SDX_ST_TURN) begin
      drive_nxt.out  = 1'b0;
      drive_nxt.oe_n = 1'b1;
    end else begin
      drive_nxt = sdx_mode_drive(cur_nxt, core_do);
    end
  end

  assign busy = (state == SDX_ST_TURN);

  logic sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
    end
  end

`ifdef SDX_GLITCH_FILT_EN
  localparam int            CW        = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_LEN - 1);

  logic [CW-1:0] filt_cnt;
  logic          filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt <= '0;
      filt_q   <= 1'b1;
    end else if (sync2 == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_q   <= sync2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign core_di = filt_q;
`else
  assign core_di = sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/sdx_pad_ctrl.sv
`default_nettype none
// ============================================================================
// sdx_pad_ctrl : multi-channel SDX pad controller (HIZ / OD / PP per channel).
// Glitch filter present only when SDX_GLITCH_FILT_EN is defined.
// Rev 1.0
// ============================================================================
module sdx_pad_ctrl
  import sdx_pad_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int FILT_LEN = SDX_FILT_LEN_DEF,
  parameter int TURN_CYC = SDX_TURN_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   mode_we,
  input  logic [NUM_CH-1:0]   core_do,
  output logic [NUM_CH-1:0]   core_di,
  output logic [NUM_CH-1:0]   busy,
  input  logic [NUM_CH-1:0]   pad_in,
  output logic [NUM_CH-1:0]   pad_out,
  output logic [NUM_CH-1:0]   pad_oe_n
);

  if ((NUM_CH < 1) || (NUM_CH > 16) || (FILT_LEN < 1) || (FILT_LEN > 255) ||
      (TURN_CYC < 1) || (TURN_CYC > 255)) begin : g_param_check
    $error("sdx_pad_ctrl: parameter out of range");
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    sdx_pad_chan #(
      .TURN_CYC(TURN_CYC)
`ifdef SDX_GLITCH_FILT_EN
      ,
      .FILT_LEN(FILT_LEN)
`endif
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .mode_in (mode_i[2*n +: 2]),
      .mode_we (mode_we[n]),
      .core_do (core_do[n]),
      .pad_in  (pad_in[n]),
      .core_di (core_di[n]),
      .busy    (busy[n]),
      .pad_out (pad_out[n]),
      .pad_oe_n(pad_oe_n[n])
    );
  end

endmodule
`default_nettype wire
